// File: rtl/sync_fifo_core.sv
// Single-clock FIFO between the UART command controller and the UART transmitter.
// Define SYNC_FIFO_STATUS_EN to add ALMOST_LEVEL and the almost/overflow/underflow status ports.
module sync_fifo_core #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
`ifdef SYNC_FIFO_STATUS_EN
  ,
  parameter int ALMOST_LEVEL = 2
`endif
) (
  input  logic                 clk_in,
  input  logic                 n_rst,
  input  logic                 wr_en_in,
  input  logic [DATA_BITS-1:0] wr_data_in,
  input  logic                 rd_en_in,
  output logic [DATA_BITS-1:0] rd_data_out,
  output logic                 full_out,
  output logic                 empty_out,
  output logic [ADDR_BITS:0]   count_out
`ifdef SYNC_FIFO_STATUS_EN
  ,
  output logic                 almost_full_out,
  output logic                 almost_empty_out,
  output logic                 overflow_out,
  output logic                 underflow_out
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] PTR_ONE = (ADDR_BITS+1)'(1);

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [ADDR_BITS:0]   wr_ptr_reg;
  logic [ADDR_BITS:0]   wr_ptr_next;
  logic [ADDR_BITS:0]   rd_ptr_reg;
  logic [ADDR_BITS:0]   rd_ptr_next;
  logic [DATA_BITS-1:0] rd_data_reg;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 full_flag;
  logic                 empty_flag;
  logic [ADDR_BITS:0]   count_val;

  // Flags depend only on the registered pointers, so no input reaches an output combinationally.
  always_comb begin
    empty_flag = (wr_ptr_reg == rd_ptr_reg);
    full_flag  = (wr_ptr_reg[ADDR_BITS] != rd_ptr_reg[ADDR_BITS]) &&
                 (wr_ptr_reg[ADDR_BITS-1:0] == rd_ptr_reg[ADDR_BITS-1:0]);
    count_val  = wr_ptr_reg - rd_ptr_reg;
  end

  always_comb begin
    wr_acc      = wr_en_in & ~full_flag;
    rd_acc      = rd_en_in & ~empty_flag;
    wr_ptr_next = wr_acc ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;
    rd_ptr_next = rd_acc ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;
  end

  // Storage is left unreset so it can map onto block RAM.
  always_ff @(posedge clk_in) begin
    if (wr_acc) begin
      mem[wr_ptr_reg[ADDR_BITS-1:0]] <= wr_data_in;
    end
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Registered read port; holds the last word when no read is accepted.
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      rd_data_reg <= '0;
    end else if (rd_acc) begin
      rd_data_reg <= mem[rd_ptr_reg[ADDR_BITS-1:0]];
    end
  end

  assign rd_data_out = rd_data_reg;
  assign full_out    = full_flag;
  assign empty_out   = empty_flag;
  assign count_out   = count_val;

`ifdef SYNC_FIFO_STATUS_EN
  localparam logic [ADDR_BITS:0] AF_LEVEL = (ADDR_BITS+1)'(DEPTH - ALMOST_LEVEL);
  localparam logic [ADDR_BITS:0] AE_LEVEL = (ADDR_BITS+1)'(ALMOST_LEVEL);

  logic overflow_reg;
  logic overflow_next;
  logic underflow_reg;
  logic underflow_next;

  // Sticky error flags record any rejected request until the next reset.
  always_comb begin
    overflow_next  = overflow_reg  | (wr_en_in & full_flag);
    underflow_next = underflow_reg | (rd_en_in & empty_flag);
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign almost_full_out  = (count_val >= AF_LEVEL);
  assign almost_empty_out = (count_val <= AE_LEVEL);
  assign overflow_out     = overflow_reg;
  assign underflow_out    = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_core.sv
// Randomised and directed bench for sync_fifo_core against a queue-based reference model.
// Status-port checks are compiled in when SYNC_FIFO_STATUS_EN is defined.
module tb_sync_fifo_core;

  localparam int DATA_BITS = 8;
  localparam int ADDR_BITS = 4;
  localparam int DEPTH     = 16;
  localparam int ALMOST    = 2;

  logic                 clk_in;
  logic                 n_rst;
  logic                 wr_en_in;
  logic [DATA_BITS-1:0] wr_data_in;
  logic                 rd_en_in;
  logic [DATA_BITS-1:0] rd_data_out;
  logic                 full_out;
  logic                 empty_out;
  logic [ADDR_BITS:0]   count_out;
`ifdef SYNC_FIFO_STATUS_EN
  logic                 almost_full_out;
  logic                 almost_empty_out;
  logic                 overflow_out;
  logic                 underflow_out;
`endif

  sync_fifo_core #(
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS)
`ifdef SYNC_FIFO_STATUS_EN
    ,
    .ALMOST_LEVEL(ALMOST)
`endif
  ) dut (
    .clk_in(clk_in),
    .n_rst(n_rst),
    .wr_en_in(wr_en_in),
    .wr_data_in(wr_data_in),
    .rd_en_in(rd_en_in),
    .rd_data_out(rd_data_out),
    .full_out(full_out),
    .empty_out(empty_out),
    .count_out(count_out)
`ifdef SYNC_FIFO_STATUS_EN
    ,
    .almost_full_out(almost_full_out),
    .almost_empty_out(almost_empty_out),
    .overflow_out(overflow_out),
    .underflow_out(underflow_out)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents in arrival order plus the expected read register.
  logic [DATA_BITS-1:0] model_q [$];
  logic [DATA_BITS-1:0] exp_rd;
  logic                 exp_ovf;
  logic                 exp_unf;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_count"}, 32'(count_out), 32'(model_q.size()));
    check_val({tag, "_empty"}, 32'(empty_out), 32'(model_q.size() == 0));
    check_val({tag, "_full"}, 32'(full_out), 32'(model_q.size() == DEPTH));
    check_val({tag, "_rdata"}, 32'(rd_data_out), 32'(exp_rd));
`ifdef SYNC_FIFO_STATUS_EN
    check_val({tag, "_afull"}, 32'(almost_full_out), 32'(model_q.size() >= DEPTH - ALMOST));
    check_val({tag, "_aempty"}, 32'(almost_empty_out), 32'(model_q.size() <= ALMOST));
    check_val({tag, "_ovf"}, 32'(overflow_out), 32'(exp_ovf));
    check_val({tag, "_unf"}, 32'(underflow_out), 32'(exp_unf));
`endif
  endtask

  // One clocked transaction: drive, clock, update model from pre-edge occupancy, compare.
  task automatic step(input string tag, input logic wr, input logic [DATA_BITS-1:0] data,
                      input logic rd);
    bit was_full;
    bit was_empty;
    wr_en_in   = wr;
    wr_data_in = data;
    rd_en_in   = rd;
    was_full   = (model_q.size() == DEPTH);
    was_empty  = (model_q.size() == 0);
    @(posedge clk_in);
    #1;
    if (rd && !was_empty) exp_rd = model_q.pop_front();
    if (wr && !was_full) model_q.push_back(data);
    if (wr && was_full) exp_ovf = 1'b1;
    if (rd && was_empty) exp_unf = 1'b1;
    $display("%s wr=%0d d=%02h rd=%0d -> rd_data=%02h count=%0d", tag, wr, data, rd,
             rd_data_out, count_out);
    check_state(tag);
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_rd  = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  initial begin
    int bias_wr;
    int bias_rd;
    n_rst      = 1'b0;
    wr_en_in   = 1'b0;
    wr_data_in = '0;
    rd_en_in   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check_state("reset");
    @(negedge clk_in);
    n_rst = 1'b1;

    for (int i = 0; i < 5; i++) step("idle", 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0);
    check_val("full_after_16", 32'(full_out), 32'd1);
    step("overfill", 1'b1, 8'hAA, 1'b0);

    for (int i = 0; i < 16; i++) begin
      step("drain", 1'b0, 8'h00, 1'b1);
      check_val("drain_order", 32'(rd_data_out), 32'(i));
    end
    step("underread", 1'b0, 8'h00, 1'b1);
    check_val("underread_hold", 32'(rd_data_out), 32'h0F);

    for (int i = 0; i < 3; i++) step("wrap_pre", 1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step("wrap", 1'b1, 8'(8'h13 + i), 1'b1);
      check_val("wrap_seq", 32'(rd_data_out), 32'(8'h10 + i));
    end

    for (int i = 0; i < 3; i++) step("flush", 1'b0, 8'h00, 1'b1);
    step("both_empty", 1'b1, 8'h55, 1'b1);
    check_val("both_empty_count", 32'(count_out), 32'd1);
    for (int i = 0; i < 15; i++) step("refill", 1'b1, 8'(8'h60 + i), 1'b0);
    step("both_full", 1'b1, 8'hEE, 1'b1);
    check_val("both_full_count", 32'(count_out), 32'd15);
    check_val("both_full_oldest", 32'(rd_data_out), 32'h55);

    for (int i = 0; i < 15; i++) step("empty_out", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) step("burst", 1'b1, 8'(8'hA0 + i), 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    check_val("async_rst_empty", 32'(empty_out), 32'd1);
    check_val("async_rst_count", 32'(count_out), 32'd0);
    check_state("async_rst");
    @(negedge clk_in);
    n_rst = 1'b1;
    step("post_rst_wr", 1'b1, 8'h3C, 1'b0);
    step("post_rst_rd", 1'b0, 8'h00, 1'b1);
    check_val("post_rst_data", 32'(rd_data_out), 32'h3C);

    for (int seg = 0; seg < 6; seg++) begin
      bias_wr = (seg % 3 == 0) ? 85 : (seg % 3 == 1) ? 20 : 50;
      bias_rd = (seg % 3 == 0) ? 20 : (seg % 3 == 1) ? 85 : 50;
      for (int i = 0; i < 100; i++) begin
        step("rand", 1'($urandom_range(0, 99) < bias_wr), 8'($urandom),
             1'($urandom_range(0, 99) < bias_rd));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_core.md
Name: sync_fifo_core

Overview:
- Synchronous single-clock FIFO. It is the storage stage between the UART-driven write/read controller and the UART transmitter.
- Accepts bytes on the write port when the controller asserts fifo_wr_en.
- Returns bytes on the read port, registered, when the controller asserts fifo_rd_en.
- Exposes full, empty and occupancy to the controller.

Parameters:
- DATA_BITS, 8, width of each stored word.
- ADDR_BITS, 4, log2 of depth; DEPTH = 2**ADDR_BITS (default 16 entries).

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- wr_en_in  input  1  write request.
- wr_data_in  input  DATA_BITS  write data.
- rd_en_in  input  1  read request.
- rd_data_out  output  DATA_BITS  registered read data.
- full_out  output  1  FIFO holds DEPTH words.
- empty_out  output  1  FIFO holds 0 words.
- count_out  output  ADDR_BITS+1  current occupancy, 0..DEPTH.
- almost_full_out  output  1  present only with SYNC_FIFO_STATUS_EN.
- almost_empty_out  output  1  present only with SYNC_FIFO_STATUS_EN.
- overflow_out  output  1  present only with SYNC_FIFO_STATUS_EN.
- underflow_out  output  1  present only with SYNC_FIFO_STATUS_EN.

Behaviour:
- Single clock, clk_in. Reset is asynchronous and active-low on n_rst.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0.
  - rd_data_out = 0, count_out = 0, empty_out = 1, full_out = 0.
  - Optional outputs: almost_empty_out = 1, others 0.
  - Storage array is not reset.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_BITS+1 bits.
  - The low ADDR_BITS bits index memory; the MSB is the wrap bit.
  - Pointers increment modulo 2**(ADDR_BITS+1), with natural wrap-around.
- Flags, combinational from the registered pointers only (no input-to-output paths):
  - empty_out = (wr_ptr == rd_ptr).
  - full_out = (MSBs differ) and (low bits equal).
  - count_out = wr_ptr - rd_ptr, (ADDR_BITS+1)-bit unsigned subtraction.
- Write accept: wr_acc = wr_en_in & ~full_out. On the edge, mem[wr_ptr low bits] <= wr_data_in and wr_ptr increments.
- Read accept: rd_acc = rd_en_in & ~empty_out. On the edge, rd_data_out <= mem[rd_ptr low bits] and rd_ptr increments.
- Read latency is 1 cycle: data appears on rd_data_out the cycle after rd_en_in is sampled high with the FIFO not empty.
- rd_data_out holds its last value when no read is accepted.
- Rejected requests (write while full, read while empty) change no state.
- Simultaneous write and read:
  - Not full and not empty: both accepted; count unchanged; rd_data_out gets the oldest word.
  - Full: read accepted, write rejected (flags are evaluated pre-edge); count becomes DEPTH-1.
  - Empty: write accepted, read rejected; rd_data_out unchanged; count becomes 1. No write-through.
- Reset mid-operation: pointers and flags return to reset values immediately and asynchronously. Stored data is discarded logically.
- There is no state machine beyond the pointers; all sequential state is the pointers, rd_data_out, the memory, and the optional sticky flags.

Optional Feature:
- Macro SYNC_FIFO_STATUS_EN. When defined, add parameter ALMOST_LEVEL (default 2) and the four status ports:
  - almost_full_out = (count_out >= DEPTH - ALMOST_LEVEL).
  - almost_empty_out = (count_out <= ALMOST_LEVEL).
  - overflow_out: sticky; set on the edge where wr_en_in & full_out.
  - underflow_out: sticky; set on the edge where rd_en_in & empty_out.
  - Both sticky flags clear only on n_rst.
- When undefined, the ports, parameter and logic are absent. Core behaviour is identical in both builds.

Test Plan:
- Reset then idle 5 cycles -> empty_out=1, full_out=0, count_out=0, rd_data_out=0.
- Write 0x00..0x0F on 16 consecutive cycles -> full_out=1 after the 16th edge, count_out=16. A 17th write of 0xAA is ignored and, with SYNC_FIFO_STATUS_EN, overflow_out=1.
- From full, read 16 cycles -> rd_data_out shows 0x00..0x0F in order, each one cycle after its rd_en_in. empty_out=1 after the last read. A further read leaves rd_data_out=0x0F and, with SYNC_FIFO_STATUS_EN, sets underflow_out=1.
- Wrap: 3 cycles of write-only 0x10..0x12, then 40 cycles of simultaneous write (0x13 onward) and read -> count_out stays 3 throughout; reads return 0x10,0x11,0x12,0x13... in sequence across pointer wrap.
- Simultaneous wr_en_in/rd_en_in while empty with data 0x55 -> count_out=1, rd_data_out unchanged. While full -> count_out=15, oldest word on rd_data_out, write data dropped.
- Assert n_rst low mid-burst with count_out=7 -> empty_out=1 and count_out=0 before the next clock edge. Subsequent write/read of 0x3C returns 0x3C.
